// File: rtl/sum_accum_pkg.sv
// Shared types, default sizes and width helper for the sum_accum frame accumulator.
// Optional feature macro used by this slice: SUM_ACCUM_FLUSH_EN.
package sum_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } sum_accum_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_COUNT = 4;

  // Accumulator width that can hold COUNT full-scale samples without wrapping.
  function automatic int acc_w(input int width, input int count);
    return width + $clog2(count);
  endfunction

endpackage

// File: rtl/sum_accum_ctr.sv
// Sample counter for sum_accum: clear has priority over increment, and o_last
// flags the count value at which the next increment completes a frame.
module sum_accum_ctr #(
  parameter  int COUNT = 4,
  localparam int CNT_W = $clog2(COUNT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/sum_accum.sv
// Frame accumulator: sums COUNT accepted samples and presents the total on a
// valid/ready output. Define SUM_ACCUM_FLUSH_EN to add the early-flush input.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int COUNT = DEFAULT_COUNT,
  localparam int ACC_W = acc_w(WIDTH, COUNT),
  localparam int CNT_W = $clog2(COUNT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
`ifdef SUM_ACCUM_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  sum_accum_state_t r_state;
  sum_accum_state_t w_nextState;

  logic             w_inReady;
  logic             w_outValid;
  logic             w_xfer;
  logic             w_endFrame;
  logic             w_ctrLast;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_frameCnt;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_outData;
  logic [CNT_W-1:0] r_outCnt;

  sum_accum_ctr #(
    .COUNT (COUNT)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_endFrame),
    .i_inc  (w_xfer),
    .o_cnt  (w_cnt),
    .o_last (w_ctrLast)
  );

  assign w_sum      = r_acc + {{(ACC_W - WIDTH){1'b0}}, in_data};
  assign w_frameCnt = w_cnt + CNT_W'(w_xfer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_nextState;
    end
  end

  // in_ready is held low while reset is asserted, otherwise it follows the state.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    w_xfer      = 1'b0;
    w_endFrame  = 1'b0;
    case (r_state)
      ACCUM: begin
        w_inReady  = ~rst;
        w_xfer     = in_valid & w_inReady;
`ifdef SUM_ACCUM_FLUSH_EN
        w_endFrame = (w_xfer & w_ctrLast) |
                     (flush & ~rst & (w_xfer | (w_cnt != '0)));
`else
        w_endFrame = w_xfer & w_ctrLast;
`endif
        if (w_endFrame) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        w_outValid = 1'b1;
        if (out_ready) begin
          w_nextState = ACCUM;
        end
      end
      default: begin
        w_nextState = ACCUM;
      end
    endcase
  end

  // A frame can end without a same-cycle transfer only through flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_outData <= '0;
      r_outCnt  <= '0;
    end else if (w_endFrame) begin
      r_outData <= w_xfer ? w_sum : r_acc;
      r_outCnt  <= w_frameCnt;
      r_acc     <= '0;
    end else if (w_xfer) begin
      r_acc <= w_sum;
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = w_outValid;
  assign out_data  = r_outData;
  assign out_cnt   = r_outCnt;

endmodule

// File: tb/tb_sum_accum.sv
// Self-checking bench for sum_accum: a queue-based frame model checked every
// cycle, plus directed frames with hand-computed totals.
module tb_sum_accum;

  localparam int WIDTH = 8;
  localparam int COUNT = 4;
  localparam int ACC_W = WIDTH + $clog2(COUNT);
  localparam int CNT_W = $clog2(COUNT) + 1;
`ifdef SUM_ACCUM_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             flush;

  int nTests = 0;
  int nFail  = 0;
  bit started = 1'b0;

  sum_accum #(
    .WIDTH (WIDTH),
    .COUNT (COUNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
`ifdef SUM_ACCUM_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame model: samples collect in a queue; a full (or flushed) queue becomes
  // the held total until the consumer takes it.
  int unsigned sampleQ[$];
  bit          mHold = 1'b0;
  int unsigned mData = 0;
  int unsigned mCnt  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sampleQ.delete();
      mHold = 1'b0;
      mData = 0;
      mCnt  = 0;
    end else if (mHold) begin
      if (out_ready) mHold = 1'b0;
    end else begin
      if (in_valid) sampleQ.push_back(int'(in_data));
      if (sampleQ.size() == COUNT || (FLUSH_EN && flush && sampleQ.size() > 0)) begin
        mData = 0;
        foreach (sampleQ[k]) mData += sampleQ[k];
        mCnt  = sampleQ.size();
        sampleQ.delete();
        mHold = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      if (rst) begin
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_cnt", 32'(out_cnt), 0);
      end else begin
        check("model_in_ready", 32'(in_ready), 32'(!mHold));
        check("model_out_valid", 32'(out_valid), 32'(mHold));
        if (mHold) begin
          check("model_out_data", 32'(out_data), mData);
          check("model_out_cnt", 32'(out_cnt), mCnt);
        end
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int gap);
    bit ok = 1'b0;
    int w = 0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #2;
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && w < 20) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #2;
      w++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int expData, input int expCnt, input int maxWait);
    bit seen = 1'b0;
    int w = 0;
    while (!seen && w < maxWait) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
      w++;
    end
    check({name, "_valid"}, 32'(seen), 1);
    if (seen) begin
      check({name, "_data"}, 32'(out_data), expData);
      check({name, "_cnt"}, 32'(out_cnt), expCnt);
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    flush     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    check("por_in_ready", 32'(in_ready), 0);
    check("por_out_valid", 32'(out_valid), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    // Basic frame, back-to-back samples.
    applyStimulus(8'd10, 0);
    applyStimulus(8'd20, 0);
    applyStimulus(8'd30, 0);
    applyStimulus(8'd40, 0);
    checkOutput("basic", 100, 4, 1);
    @(negedge clk);
    check("basic_ready_back", 32'(in_ready), 1);
    @(posedge clk);
    #2;

    // Full-scale samples.
    for (int i = 0; i < COUNT; i++) applyStimulus(8'd255, 0);
    checkOutput("max", 1020, 4, 1);

    // Gaps between samples, then backpressure with input waiting.
    out_ready = 1'b0;
    applyStimulus(8'd3, 2);
    applyStimulus(8'd50, 1);
    applyStimulus(8'd7, 3);
    applyStimulus(8'd200, 0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    checkOutput("gaps", 260, 4, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 260);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    #2 in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 1);
    check("bp_release_valid", 32'(out_valid), 0);
    @(posedge clk);
    #2;

    // Reset mid-frame discards the partial sum.
    applyStimulus(8'd9, 0);
    applyStimulus(8'd9, 0);
    #1 rst = 1'b1;
    #1;
    check("midframe_in_ready", 32'(in_ready), 0);
    check("midframe_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #2;
    for (int i = 0; i < COUNT; i++) applyStimulus(8'd1, 0);
    checkOutput("after_rst", 4, 4, 1);

    // Reset during HOLD discards the pending total.
    out_ready = 1'b0;
    applyStimulus(8'd1, 0);
    applyStimulus(8'd2, 0);
    applyStimulus(8'd3, 0);
    applyStimulus(8'd4, 0);
    checkOutput("pre_hold_rst", 10, 4, 1);
    #1 rst = 1'b1;
    #1;
    check("hold_rst_valid", 32'(out_valid), 0);
    check("hold_rst_data", 32'(out_data), 0);
    check("hold_rst_cnt", 32'(out_cnt), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;

    // Back-to-back frames: second frame waits out the handshake cycle.
    applyStimulus(8'd1, 0);
    applyStimulus(8'd2, 0);
    applyStimulus(8'd3, 0);
    applyStimulus(8'd4, 0);
    applyStimulus(8'd5, 0);
    applyStimulus(8'd6, 0);
    applyStimulus(8'd7, 0);
    applyStimulus(8'd8, 0);
    checkOutput("b2b", 26, 4, 1);

`ifdef SUM_ACCUM_FLUSH_EN
    applyStimulus(8'd5, 0);
    applyStimulus(8'd7, 0);
    flush = 1'b1;
    applyStimulus(8'd9, 0);
    flush = 1'b0;
    checkOutput("flush_xfer", 21, 3, 1);
    flush = 1'b1;
    @(posedge clk);
    #2 flush = 1'b0;
    @(negedge clk);
    check("flush_empty_valid", 32'(out_valid), 0);
    @(posedge clk);
    #2;
    applyStimulus(8'd6, 0);
    flush = 1'b1;
    @(posedge clk);
    #2 flush = 1'b0;
    checkOutput("flush_only", 6, 1, 1);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
